rto_write_scheduler: RTL and testbench

Front-end controller for one RTO output core. It round-robin arbitrates timed 128-bit entries from NUM_REQ requesters into the core FIFO write port and rejects entries whose timestamp is too close to the running counter. It also sequences the core's flush and auto_start lines through a small run-control state machine. It sits between the host/sequencer write sources and the RTO core.

---
 rtl/rto_write_scheduler_if.sv | 12 +
 rtl/rto_write_scheduler.sv | 151 +++++++++++++++
 tb/tb_rto_write_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rto_write_scheduler_if.sv
// Requester-side bus of the RTO write scheduler: per-requester valid/ready
// and a packed array of 128-bit timed entries.
interface rto_write_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     valid;
    logic [NUM_REQ*128-1:0] data;
    logic [NUM_REQ-1:0]     ready;

    modport master (output valid, data, input ready);
    modport slave  (input valid, data, output ready);
endinterface

// File: rtl/rto_write_scheduler.sv
// Round-robin front end for one RTO output core: arbitrates timed entries into
// the core FIFO, drops late entries, and sequences flush/auto_start.
module rto_write_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int LEAD_CYCLES  = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    rto_write_scheduler_if.slave  req,
    input  logic                  start_cmd,
    input  logic                  stop_cmd,
    input  logic [63:0]           counter,
    input  logic                  core_full,
    input  logic                  core_timestamp_error,
    input  logic                  core_overflow_error,
    output logic                  core_write,
    output logic [127:0]          core_din,
    output logic                  core_flush,
    output logic                  core_auto_start,
    output logic                  late_drop,
    output logic [2:0]            late_drop_src,
    output logic [31:0]           drop_count,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t         state_q;
    state_t         state_nxt;
    logic [FCW-1:0] flush_cnt;
    logic [2:0]     rr_ptr;       // first index searched on the next grant
    logic [2:0]     grant_idx;
    logic           grant_found;
    logic           eligible;
    logic [127:0]   grant_entry;
    logic           grant_late;

    // One write in flight at a time, and nothing while the core is held.
    assign eligible = !reset && (state_q == S_IDLE || state_q == S_RUN)
                      && !core_full && !core_write;

    // Two passes over the requesters: first from rr_ptr upward, then wrap to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (eligible) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_found && req.valid[j] && 3'(j) >= rr_ptr) begin
                    grant_found = 1'b1;
                    grant_idx   = 3'(j);
                end
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_found && req.valid[j]) begin
                    grant_found = 1'b1;
                    grant_idx   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        grant_entry = '0;
        req.ready   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_found && 3'(j) == grant_idx) begin
                grant_entry  = req.data[128*j +: 128];
                req.ready[j] = 1'b1;
            end
        end
    end

    // 65-bit compare so counter + LEAD_CYCLES never wraps past a small timestamp.
    assign grant_late = {1'b0, grant_entry[95:32]} < ({1'b0, counter} + 65'(LEAD_CYCLES));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order between blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_write    <= 1'b0;
            core_din      <= '0;
            late_drop     <= 1'b0;
            late_drop_src <= '0;
            drop_count    <= '0;
            rr_ptr        <= '0;
        end else begin
            core_write <= grant_found && !grant_late;
            late_drop  <= grant_found && grant_late;
            if (grant_found) begin
                rr_ptr <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
                if (grant_late) begin
                    late_drop_src <= grant_idx;
                    if (drop_count != '1)
                        drop_count <= drop_count + 32'd1;
                end else begin
                    core_din <= grant_entry;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (stop_cmd)       state_nxt = S_FLUSH;
                else if (start_cmd) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_timestamp_error || core_overflow_error) state_nxt = S_HALT;
                else if (stop_cmd)                               state_nxt = S_FLUSH;
            end
            S_HALT: begin
                if (stop_cmd) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Core control lines are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            flush_cnt       <= '0;
            core_flush      <= 1'b0;
            core_auto_start <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            core_flush      <= (state_nxt == S_FLUSH);
            core_auto_start <= (state_nxt == S_RUN);
            if (state_q != S_FLUSH && state_nxt == S_FLUSH)
                flush_cnt <= FCW'(FLUSH_CYCLES - 1);
            else if (state_q == S_FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_rto_write_scheduler.sv
// Directed bench for rto_write_scheduler: expected writes are queued as stimulus
// is driven and popped when core_write fires.
module tb_rto_write_scheduler;

    localparam int NUM_REQ = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_cmd;
    logic         stop_cmd;
    logic [63:0]  counter;
    logic         core_full;
    logic         core_timestamp_error;
    logic         core_overflow_error;
    logic         core_write;
    logic [127:0] core_din;
    logic         core_flush;
    logic         core_auto_start;
    logic         late_drop;
    logic [2:0]   late_drop_src;
    logic [31:0]  drop_count;
    logic [1:0]   state;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    rto_write_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    rto_write_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .LEAD_CYCLES  (8),
        .FLUSH_CYCLES (4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req                  (bus),
        .start_cmd            (start_cmd),
        .stop_cmd             (stop_cmd),
        .counter              (counter),
        .core_full            (core_full),
        .core_timestamp_error (core_timestamp_error),
        .core_overflow_error  (core_overflow_error),
        .core_write           (core_write),
        .core_din             (core_din),
        .core_flush           (core_flush),
        .core_auto_start      (core_auto_start),
        .late_drop            (late_drop),
        .late_drop_src        (late_drop_src),
        .drop_count           (drop_count),
        .state                (state)
    );

    function automatic logic [127:0] mk_entry(input int idx, input logic [63:0] ts);
        return {32'hA5A5_0000 + 32'(idx), ts, 32'h0000_C000 + 32'(idx)};
    endfunction

    task automatic set_req(input int idx, input logic [63:0] ts);
        bus.data[128*idx +: 128] = mk_entry(idx, ts);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag);
        logic [127:0] exp;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed write with empty scoreboard, expected none", tag);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_we"}, 128'(core_write), 128'(1));
            check({tag, "_din"}, core_din, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[5];
        logic [3:0] exp_r;
        order = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        start_cmd = 1'b0;
        stop_cmd = 1'b0;
        counter = '0;
        core_full = 1'b0;
        core_timestamp_error = 1'b0;
        core_overflow_error = 1'b0;
        bus.valid = '0;
        bus.data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_state", 128'(state), 128'(0));
        check("rst_we", 128'(core_write), 128'(0));
        check("rst_din", core_din, 128'(0));
        check("rst_flush", 128'(core_flush), 128'(0));
        check("rst_auto", 128'(core_auto_start), 128'(0));
        check("rst_late", 128'(late_drop), 128'(0));
        check("rst_src", 128'(late_drop_src), 128'(0));
        check("rst_cnt", 128'(drop_count), 128'(0));
        check("rst_ready", 128'(bus.ready), 128'(0));

        // Round robin, all requesters valid in IDLE
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(1000 + i));
        bus.valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_r = 4'b0001 << order[k];
            check($sformatf("rr_ready%0d", k), 128'(bus.ready), 128'(exp_r));
            exp_q.push_back(mk_entry(order[k], 64'(1000 + order[k])));
            step();
            check_write($sformatf("rr_write%0d", k));
            check($sformatf("rr_gap%0d", k), 128'(bus.ready), 128'(0));
            if (k == 4) bus.valid = '0;
            step();
        end

        // RUN, late entry dropped, then boundary-equal accepted
        counter = 64'd100;
        start_cmd = 1'b1;
        step();
        start_cmd = 1'b0;
        check("run_state", 128'(state), 128'(1));
        check("run_auto", 128'(core_auto_start), 128'(1));
        set_req(2, 64'd105);
        bus.valid = 4'b0100;
        #1;
        check("late_ready", 128'(bus.ready), 128'(4'b0100));
        step();
        check("late_we", 128'(core_write), 128'(0));
        check("late_pulse", 128'(late_drop), 128'(1));
        check("late_src", 128'(late_drop_src), 128'(2));
        check("late_cnt", 128'(drop_count), 128'(1));
        set_req(2, 64'd108);
        #1;
        check("edge_ready", 128'(bus.ready), 128'(4'b0100));
        exp_q.push_back(mk_entry(2, 64'd108));
        step();
        check_write("edge_write");
        check("edge_nolate", 128'(late_drop), 128'(0));
        bus.valid = '0;
        step();

        // Counter near 2^64: sum must not wrap
        counter = 64'hFFFF_FFFF_FFFF_FFFC;
        set_req(3, 64'd4);
        bus.valid = 4'b1000;
        #1;
        check("wrap_ready", 128'(bus.ready), 128'(4'b1000));
        step();
        check("wrap_we", 128'(core_write), 128'(0));
        check("wrap_late", 128'(late_drop), 128'(1));
        check("wrap_src", 128'(late_drop_src), 128'(3));
        check("wrap_cnt", 128'(drop_count), 128'(2));
        set_req(3, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        check("wrap2_ready", 128'(bus.ready), 128'(4'b1000));
        step();
        check("wrap2_we", 128'(core_write), 128'(0));
        check("wrap2_cnt", 128'(drop_count), 128'(3));
        bus.valid = '0;
        step();
        check("wrap2_pulse_end", 128'(late_drop), 128'(0));
        counter = 64'd100;

        // core_full blocks grants; resume at RR index 0
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(2000 + i));
        core_full = 1'b1;
        bus.valid = 4'hF;
        #1;
        check("full_ready0", 128'(bus.ready), 128'(0));
        for (int c = 1; c < 4; c++) begin
            step();
            check($sformatf("full_ready%0d", c), 128'(bus.ready), 128'(0));
            check($sformatf("full_we%0d", c), 128'(core_write), 128'(0));
        end
        core_full = 1'b0;
        #1;
        check("full_resume", 128'(bus.ready), 128'(4'b0001));
        exp_q.push_back(mk_entry(0, 64'd2000));
        step();
        check_write("full_write");
        bus.valid = '0;
        step();

        // RUN -> HALT on timestamp error, start ignored, stop -> 4 flush cycles
        core_timestamp_error = 1'b1;
        step();
        core_timestamp_error = 1'b0;
        check("halt_state", 128'(state), 128'(2));
        check("halt_auto", 128'(core_auto_start), 128'(0));
        bus.valid = 4'hF;
        #1;
        check("halt_ready", 128'(bus.ready), 128'(0));
        start_cmd = 1'b1;
        step();
        start_cmd = 1'b0;
        check("halt_start_ign", 128'(state), 128'(2));
        check("halt_we", 128'(core_write), 128'(0));
        stop_cmd = 1'b1;
        step();
        stop_cmd = 1'b0;
        check("fl_state", 128'(state), 128'(3));
        check("fl_flush1", 128'(core_flush), 128'(1));
        check("fl_ready", 128'(bus.ready), 128'(0));
        start_cmd = 1'b1;
        step();
        start_cmd = 1'b0;
        check("fl_flush2", 128'(core_flush), 128'(1));
        check("fl_auto", 128'(core_auto_start), 128'(0));
        step();
        check("fl_flush3", 128'(core_flush), 128'(1));
        step();
        check("fl_flush4", 128'(core_flush), 128'(1));
        check("fl_state4", 128'(state), 128'(3));
        bus.valid = '0;
        step();
        check("fl_done_flush", 128'(core_flush), 128'(0));
        check("fl_done_state", 128'(state), 128'(0));

        // Simultaneous commands
        start_cmd = 1'b1;
        stop_cmd = 1'b1;
        step();
        start_cmd = 1'b0;
        stop_cmd = 1'b0;
        check("both_idle_state", 128'(state), 128'(3));
        check("both_idle_auto", 128'(core_auto_start), 128'(0));
        repeat (4) step();
        check("both_idle_back", 128'(state), 128'(0));
        start_cmd = 1'b1;
        step();
        start_cmd = 1'b0;
        check("both_run", 128'(state), 128'(1));
        stop_cmd = 1'b1;
        core_overflow_error = 1'b1;
        step();
        stop_cmd = 1'b0;
        core_overflow_error = 1'b0;
        check("both_run_halt", 128'(state), 128'(2));
        check("both_run_noflush", 128'(core_flush), 128'(0));
        stop_cmd = 1'b1;
        step();
        stop_cmd = 1'b0;
        check("both_halt_flush", 128'(state), 128'(3));
        repeat (4) step();
        check("both_end_idle", 128'(state), 128'(0));

        // Reset mid-FLUSH
        stop_cmd = 1'b1;
        step();
        stop_cmd = 1'b0;
        check("mid_fl_flush", 128'(core_flush), 128'(1));
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_flush", 128'(core_flush), 128'(0));
        check("mid_rst_state", 128'(state), 128'(0));
        step();
        reset = 1'b0;
        #1;

        // Reset with a write pending: the handshake edge never commits it
        set_req(2, 64'd3000);
        bus.valid = 4'b0100;
        #1;
        check("pend_ready", 128'(bus.ready), 128'(4'b0100));
        reset = 1'b1;
        #1;
        check("pend_rst_ready", 128'(bus.ready), 128'(0));
        step();
        check("pend_rst_we", 128'(core_write), 128'(0));
        check("pend_rst_din", core_din, 128'(0));
        check("pend_rst_cnt", 128'(drop_count), 128'(0));
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(3000 + i));
        bus.valid = 4'hF;
        step();
        reset = 1'b0;
        #1;
        check("post_rst_state", 128'(state), 128'(0));
        check("post_rst_ready", 128'(bus.ready), 128'(4'b0001));
        exp_q.push_back(mk_entry(0, 64'd3000));
        step();
        check_write("post_rst_write");
        bus.valid = '0;
        step();

        check("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
